// File: rtl/wb_ctrl_pipe_if.sv
// Bundle of decode-side inputs, write-back outputs and hazard query for wb_ctrl_pipe.
// The master modport is the decode/forwarding side; the slave modport is the pipe.
interface wb_ctrl_pipe_if #(
    parameter int STAGES   = 2,
    parameter int CHANNELS = 2,
    parameter int IDX_W    = 5,
    parameter int CR_W     = 8,
    parameter int SEL_W    = 10
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic                      stall;
    logic [STAGES-1:0]         kill;

    logic                      dc_valid;
    logic [CHANNELS*IDX_W-1:0] dc_dest;
    logic [CHANNELS-1:0]       dc_we;
    logic [CR_W-1:0]           dc_record_cr;
    logic                      dc_spr_we;
    logic [SEL_W-1:0]          dc_spr_sel;
    logic                      dc_msr_we;
    logic                      dc_sleep;

    logic                      wb_valid;
    logic [CHANNELS*IDX_W-1:0] wb_dest;
    logic [CHANNELS-1:0]       wb_we;
    logic [CR_W-1:0]           wb_record_cr;
    logic                      wb_spr_we;
    logic [SEL_W-1:0]          wb_spr_sel;
    logic                      wb_msr_we;
    logic                      wb_sleep;

    logic [CNT_W-1:0]          inflight;
    logic [IDX_W-1:0]          q_idx;
    logic [STAGES-1:0]         q_hit;
    logic                      q_hit_any;

    modport master (
        output stall, kill,
        output dc_valid, dc_dest, dc_we, dc_record_cr, dc_spr_we, dc_spr_sel, dc_msr_we, dc_sleep,
        output q_idx,
        input  wb_valid, wb_dest, wb_we, wb_record_cr, wb_spr_we, wb_spr_sel, wb_msr_we, wb_sleep,
        input  inflight, q_hit, q_hit_any
    );

    modport slave (
        input  stall, kill,
        input  dc_valid, dc_dest, dc_we, dc_record_cr, dc_spr_we, dc_spr_sel, dc_msr_we, dc_sleep,
        input  q_idx,
        output wb_valid, wb_dest, wb_we, wb_record_cr, wb_spr_we, wb_spr_sel, wb_msr_we, wb_sleep,
        output inflight, q_hit, q_hit_any
    );
endinterface

// File: rtl/wb_ctrl_pipe.sv
// Write-back control delay line from decode to write-back with stall, per-stage kill and
// in-flight count. Define WB_CTRL_PIPE_HAZARD_EN to build the destination hazard comparators.
module wb_ctrl_pipe #(
    parameter int STAGES   = 2,
    parameter int CHANNELS = 2,
    parameter int IDX_W    = 5,
    parameter int CR_W     = 8,
    parameter int SEL_W    = 10
) (
    input  logic            clk,
    input  logic            reset,
    wb_ctrl_pipe_if.slave   bus
);
    localparam int CNT_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic                      valid;
        logic [CHANNELS-1:0]       we;
        logic [CR_W-1:0]           record_cr;
        logic                      spr_we;
        logic                      msr_we;
        logic                      sleep;
        logic [CHANNELS*IDX_W-1:0] dest;
        logic [SEL_W-1:0]          spr_sel;
    } stage_t;

    // Kill clears only the enable class; dest and spr_sel still move or hold normally.
    function automatic stage_t squash(input stage_t s);
        stage_t r;
        r           = s;
        r.valid     = 1'b0;
        r.we        = '0;
        r.record_cr = '0;
        r.spr_we    = 1'b0;
        r.msr_we    = 1'b0;
        r.sleep     = 1'b0;
        return r;
    endfunction

    stage_t stg_q [STAGES];
    stage_t stg_d [STAGES];
    stage_t src   [STAGES];

    always_comb begin
        src[0]           = '0;
        src[0].valid     = bus.dc_valid;
        src[0].we        = bus.dc_we;
        src[0].record_cr = bus.dc_record_cr;
        src[0].spr_we    = bus.dc_spr_we;
        src[0].msr_we    = bus.dc_msr_we;
        src[0].sleep     = bus.dc_sleep;
        src[0].dest      = bus.dc_dest;
        src[0].spr_sel   = bus.dc_spr_sel;
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_chain
        assign src[g] = stg_q[g-1];
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stg_d[i] = bus.stall ? stg_q[i] : src[i];
            if (bus.kill[i]) stg_d[i] = squash(stg_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) stg_q[i] <= stg_d[i];
        end
    end

    assign bus.wb_valid     = stg_q[STAGES-1].valid;
    assign bus.wb_dest      = stg_q[STAGES-1].dest;
    assign bus.wb_we        = stg_q[STAGES-1].we;
    assign bus.wb_record_cr = stg_q[STAGES-1].record_cr;
    assign bus.wb_spr_we    = stg_q[STAGES-1].spr_we;
    assign bus.wb_spr_sel   = stg_q[STAGES-1].spr_sel;
    assign bus.wb_msr_we    = stg_q[STAGES-1].msr_we;
    assign bus.wb_sleep     = stg_q[STAGES-1].sleep;

    logic [CNT_W-1:0] cnt;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < STAGES; i++) cnt = cnt + CNT_W'(stg_q[i].valid);
    end
    assign bus.inflight = cnt;

    logic [STAGES-1:0] hit;
`ifdef WB_CTRL_PIPE_HAZARD_EN
    always_comb begin
        hit = '0;
        for (int i = 0; i < STAGES; i++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (stg_q[i].we[c] && (stg_q[i].dest[c*IDX_W +: IDX_W] == bus.q_idx))
                    hit[i] = 1'b1;
            end
        end
    end
`else
    assign hit = '0;
`endif
    assign bus.q_hit     = hit;
    assign bus.q_hit_any = |hit;
endmodule
